// File: rtl/glitch_pkg.sv
// glitch_pkg: shared types and defaults for the glitch scheduler slice.
package glitch_pkg;

    localparam int unsigned CNT_W_DEFAULT  = 32;
    localparam int unsigned NUM_W_DEFAULT  = 8;
    localparam int unsigned NUM_PULSES_MIN = 1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        PULSE,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/glitch_timer.sv
// glitch_timer: loadable down-counter shared by the delay, pulse and gap phases.
module glitch_timer
    import glitch_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority over decrement; the counter parks at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/glitch_scheduler.sv
// glitch_scheduler: arm / trigger / delay / pulse-burst sequencer driving the
// active-low glitch output. Optional delay sweep enabled by GLITCH_SWEEP_EN.
module glitch_scheduler
    import glitch_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT,
    parameter int unsigned NUM_W = NUM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [NUM_W-1:0] cfg_count,
    input  logic [CNT_W-1:0] cfg_step,
    input  logic [CNT_W-1:0] cfg_max,
    output logic             glitch_n,
    output logic             armed,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sweep_offset
);

    state_t           state;
    logic             trigger_q;
    logic             rise;
    logic [CNT_W-1:0] delay_sh;
    logic [CNT_W-1:0] width_sh;
    logic [CNT_W-1:0] gap_sh;
    logic [NUM_W-1:0] count_sh;
    logic [NUM_W-1:0] pulses_left;
    logic             last_pulse;

    logic             tmr_load;
    logic             tmr_dec;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_zero;

    assign rise       = trigger & ~trigger_q;
    assign last_pulse = (pulses_left == NUM_W'(NUM_PULSES_MIN));

    glitch_timer #(.CNT_W(CNT_W)) timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .dec   (tmr_dec),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    // Timer control: reload at each phase boundary, otherwise count down.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_value = '0;
        if (abort) begin
            tmr_load = 1'b1;
        end else begin
            case (state)
                ARMED: begin
                    if (rise) begin
                        tmr_load  = 1'b1;
                        tmr_value = delay_sh + sweep_offset;
                    end
                end
                DELAY, GAP: begin
                    if (tmr_zero) begin
                        tmr_load  = 1'b1;
                        tmr_value = width_sh;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                PULSE: begin
                    if (tmr_zero) begin
                        if (!last_pulse) begin
                            tmr_load  = 1'b1;
                            tmr_value = gap_sh;
                        end
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer with registered status outputs. done is raised from DONE so it
    // lands one cycle after glitch_n returns high; busy clears one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            trigger_q   <= 1'b0;
            glitch_n    <= 1'b1;
            armed       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulses_left <= '0;
            delay_sh    <= '0;
            width_sh    <= '0;
            gap_sh      <= '0;
            count_sh    <= '0;
        end else begin
            trigger_q <= trigger;
            done      <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                glitch_n <= 1'b1;
                armed    <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                        if (arm) begin
                            delay_sh <= cfg_delay;
                            width_sh <= cfg_width;
                            gap_sh   <= cfg_gap;
                            count_sh <= cfg_count;
                            armed    <= 1'b1;
                            busy     <= 1'b1;
                            state    <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (rise) begin
                            pulses_left <= (count_sh == '0) ? NUM_W'(NUM_PULSES_MIN) : count_sh;
                            armed       <= 1'b0;
                            state       <= DELAY;
                        end
                    end
                    DELAY, GAP: begin
                        if (tmr_zero) begin
                            glitch_n <= 1'b0;
                            state    <= PULSE;
                        end
                    end
                    PULSE: begin
                        if (tmr_zero) begin
                            glitch_n    <= 1'b1;
                            pulses_left <= pulses_left - NUM_W'(1);
                            // Testing the pre-decrement value for 1 is the same as
                            // testing the decremented count for 0.
                            state       <= last_pulse ? DONE : GAP;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef GLITCH_SWEEP_EN
    logic [CNT_W-1:0] step_sh;
    logic [CNT_W-1:0] max_sh;
    logic [CNT_W-1:0] sweep_next;
    logic             sweep_over;

    // Candidate offset after a completed attempt; overflow test uses one extra bit.
    always_comb begin
        sweep_next = sweep_offset + step_sh;
        sweep_over = ({1'b0, delay_sh} + {1'b0, sweep_next}) > {1'b0, max_sh};
    end

    // Latch sweep bounds on arm and advance the offset only on a completed burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_sh      <= '0;
            max_sh       <= '0;
            sweep_offset <= '0;
        end else if (!abort) begin
            if ((state == IDLE) && arm) begin
                step_sh <= cfg_step;
                max_sh  <= cfg_max;
            end
            if (state == DONE) begin
                sweep_offset <= sweep_over ? '0 : sweep_next;
            end
        end
    end
`else
    logic unused_sweep_cfg;

    assign unused_sweep_cfg = ^{cfg_step, cfg_max};
    assign sweep_offset     = '0;
`endif

endmodule
